// File: rtl/keccak_sponge_ctrl.sv
// keccak_sponge_ctrl: sponge sequencer for the Keccak core.
// Takes message lanes, applies SHA-3/SHAKE byte padding, XOR-writes rate
// lanes into the state array, kicks the permutation once per block and
// streams the digest lanes back out of the state.
// Optional feature: define SPONGE_BLOCK_CNT_EN to add the 16-bit blk_cnt
// output (permutations started in the current hash, saturating).
module keccak_sponge_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  mode,
   input  logic [63:0] msg_data,
   input  logic        msg_valid,
   input  logic        msg_last,
   input  logic [3:0]  msg_bytes,
   output logic        msg_ready,
   output logic        state_clr,
   output logic        lane_we,
   output logic [4:0]  lane_idx,
   output logic [63:0] lane_data,
   output logic        perm_start,
   input  logic        perm_done,
   input  logic [63:0] rd_lane,
   output logic [63:0] out_data,
   output logic        out_valid,
   output logic        out_last,
   input  logic        out_ready,
`ifdef SPONGE_BLOCK_CNT_EN
   output logic [15:0] blk_cnt,
`endif
   output logic        busy
);

   localparam int DATA_W = 64;

   typedef enum logic [2:0] {IDLE, CLEAR, ABSORB, PAD, PERM, SQUEEZE} state_t;

   state_t              state, state_d, ret_state, ret_d;
   logic [1:0]          mode_q, mode_d;
   logic [4:0]          cnt, cnt_d;
   logic                dom_pend, dom_pend_d;
   logic                perm_fired, perm_fired_d;
   logic                perm_start_q, perm_start_d;
   logic                vld_p0, vld_p0_d;
   logic [4:0]          idx_p0, idx_p0_d;
   logic [DATA_W-1:0]   data_p0, data_p0_d;
   logic [4:0]          r_last, d_last;
   logic [7:0]          dom;
   logic                at_end, sq_last;

   // Rate in lanes for each mode.
   function automatic logic [4:0] rate_lanes(input logic [1:0] m);
      case (m)
         2'd0:    return 5'd9;
         2'd1:    return 5'd13;
         2'd2:    return 5'd17;
         default: return 5'd21;
      endcase
   endfunction

   // Digest length in lanes for each mode.
   function automatic logic [4:0] digest_lanes(input logic [1:0] m);
      case (m)
         2'd0:    return 5'd8;
         2'd1:    return 5'd6;
         default: return 5'd4;
      endcase
   endfunction

   function automatic logic [7:0] domain_byte(input logic [1:0] m);
      return (m == 2'd3) ? 8'h1F : 8'h06;
   endfunction

   // Partial final lane: keep n data bytes, place the domain byte at n,
   // zero the rest; the last lane of a block also carries the 0x80 bit.
   function automatic logic [DATA_W-1:0] pad_tail(input logic [DATA_W-1:0] d,
                                                   input logic [3:0]        n,
                                                   input logic [7:0]        dbyte,
                                                   input logic              end_blk);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(n))
            r[8*i +: 8] = d[8*i +: 8];
         else if (i == int'(n))
            r[8*i +: 8] = dbyte;
      end
      if (end_blk)
         r[63:56] = r[63:56] | 8'h80;
      return r;
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_d;
   end

   // Next-state, lane-write and handshake decode.
   always_comb begin
      state_d      = state;
      ret_d        = ret_state;
      mode_d       = mode_q;
      cnt_d        = cnt;
      dom_pend_d   = dom_pend;
      perm_fired_d = perm_fired;
      perm_start_d = 1'b0;
      vld_p0_d     = 1'b0;
      idx_p0_d     = idx_p0;
      data_p0_d    = data_p0;
      r_last       = rate_lanes(mode_q) - 5'd1;
      d_last       = digest_lanes(mode_q) - 5'd1;
      dom          = domain_byte(mode_q);
      at_end       = (cnt == r_last);
      sq_last      = (cnt == d_last);
      msg_ready    = 1'b0;
      state_clr    = 1'b0;
      out_valid    = 1'b0;
      out_last     = 1'b0;
      out_data     = '0;
      lane_idx     = idx_p0;
      busy         = (state != IDLE);

      case (state)
         IDLE: begin
            if (start) begin
               mode_d  = mode;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            state_clr  = 1'b1;
            cnt_d      = '0;
            dom_pend_d = 1'b0;
            state_d    = ABSORB;
         end
         ABSORB: begin
            msg_ready = 1'b1;
            if (msg_valid) begin
               vld_p0_d = 1'b1;
               idx_p0_d = cnt;
               cnt_d    = cnt + 5'd1;
               if (!msg_last) begin
                  data_p0_d = msg_data;
                  if (at_end) begin
                     state_d = PERM;
                     ret_d   = ABSORB;
                  end
               end else if (msg_bytes < 4'd8) begin
                  data_p0_d = pad_tail(msg_data, msg_bytes, dom, at_end);
                  if (at_end) begin
                     state_d = PERM;
                     ret_d   = SQUEEZE;
                  end else begin
                     state_d = PAD;
                  end
               end else begin
                  // Full final lane: the domain byte spills into the next lane.
                  data_p0_d  = msg_data;
                  dom_pend_d = 1'b1;
                  if (at_end) begin
                     state_d = PERM;
                     ret_d   = PAD;
                  end else begin
                     state_d = PAD;
                  end
               end
            end
         end
         PAD: begin
            vld_p0_d   = 1'b1;
            idx_p0_d   = cnt;
            cnt_d      = cnt + 5'd1;
            data_p0_d  = dom_pend ? {56'd0, dom} : '0;
            dom_pend_d = 1'b0;
            if (at_end) begin
               data_p0_d[63:56] = data_p0_d[63:56] | 8'h80;
               state_d          = PERM;
               ret_d            = SQUEEZE;
            end
         end
         PERM: begin
            // Pulse once on the cycle after the block's last write lands,
            // then only listen for completion.
            if (!perm_fired) begin
               perm_start_d = 1'b1;
               perm_fired_d = 1'b1;
            end else if (perm_done) begin
               perm_fired_d = 1'b0;
               cnt_d        = '0;
               state_d      = ret_state;
            end
         end
         SQUEEZE: begin
            lane_idx  = cnt;
            out_data  = rd_lane;
            out_valid = 1'b1;
            out_last  = sq_last;
            if (out_ready) begin
               if (sq_last) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and lane-write pipeline registers (p0 = cycle after acceptance).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ret_state    <= IDLE;
         mode_q       <= '0;
         cnt          <= '0;
         dom_pend     <= 1'b0;
         perm_fired   <= 1'b0;
         perm_start_q <= 1'b0;
         vld_p0       <= 1'b0;
         idx_p0       <= '0;
         data_p0      <= '0;
      end else begin
         ret_state    <= ret_d;
         mode_q       <= mode_d;
         cnt          <= cnt_d;
         dom_pend     <= dom_pend_d;
         perm_fired   <= perm_fired_d;
         perm_start_q <= perm_start_d;
         vld_p0       <= vld_p0_d;
         idx_p0       <= idx_p0_d;
         data_p0      <= data_p0_d;
      end
   end

   assign lane_we    = vld_p0;
   assign lane_data  = data_p0;
   assign perm_start = perm_start_q;

`ifdef SPONGE_BLOCK_CNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] blk_cnt_q;

   // Count permutations of the current hash; holds once back in IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n)
         blk_cnt_q <= '0;
      else if (state == CLEAR)
         blk_cnt_q <= '0;
      else if (perm_start_q)
         blk_cnt_q <= sat_inc16(blk_cnt_q);
   end

   assign blk_cnt = blk_cnt_q;
`endif

endmodule
